// File: rtl/adv7393_timing_gen_if.sv
// Pixel-stream input and encoder-side output bundle for the ADV7393 timing generator.
// The generator attaches through the slave modport; the stream source and encoder observer use master.
interface adv7393_timing_gen_if #(
   parameter int DATA_W = 16
);
   logic              en;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_sof;
   logic              s_ready;
   logic              ic_hsync;
   logic              ic_vsync;
   logic [DATA_W-1:0] ic_data;
   logic              frame_start;
   logic              underflow;
   logic [15:0]       underflow_cnt;

   modport master (
      output en, s_data, s_valid, s_sof,
      input  s_ready, ic_hsync, ic_vsync, ic_data, frame_start, underflow, underflow_cnt
   );

   modport slave (
      input  en, s_data, s_valid, s_sof,
      output s_ready, ic_hsync, ic_vsync, ic_data, frame_start, underflow, underflow_cnt
   );
endinterface

// File: rtl/adv7393_timing_gen.sv
// Free-running video timing generator that aligns a pixel stream to frame boundaries
// and drives registered syncs and pixel data into an ADV7393 encoder.
module adv7393_timing_gen #(
   parameter int          DATA_W    = 16,
   parameter int          H_ACTIVE  = 720,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 62,
   parameter int          H_BP      = 60,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 9,
   parameter int          V_SYNC    = 6,
   parameter int          V_BP      = 30,
   parameter logic        HS_POL    = 1'b0,
   parameter logic        VS_POL    = 1'b0,
   parameter logic [15:0] BLANK_VAL = 16'h1080
) (
   input logic                 clk,
   input logic                 reset,
   adv7393_timing_gen_if.slave bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_ZERO     = HW'(0);
   localparam logic [HW-1:0] H_ONE      = HW'(1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ZERO     = VW'(0);
   localparam logic [VW-1:0] V_ONE      = VW'(1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

   localparam logic [DATA_W-1:0] BLANK_W = BLANK_VAL[DATA_W-1:0];

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SYNC_WAIT = 2'd1;
   localparam logic [1:0] ST_STREAM    = 2'd2;

   logic [1:0]        state_r;
   logic [HW-1:0]     h_cnt_r;
   logic [VW-1:0]     v_cnt_r;
   logic              ic_hsync_r;
   logic              ic_vsync_r;
   logic [DATA_W-1:0] ic_data_r;
   logic              frame_start_r;
   logic              underflow_r;
   logic [15:0]       underflow_cnt_r;

   logic [1:0]        state_nxt_s;
   logic              ready_s;
   logic [DATA_W-1:0] data_nxt_s;
   logic              fs_nxt_s;
   logic              uf_nxt_s;
   logic              active_s;
   logic              origin_s;
   logic              stop_s;
   logic              hs_region_s;
   logic              vs_region_s;

   assign active_s    = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
   assign origin_s    = (h_cnt_r == H_ZERO) && (v_cnt_r == V_ZERO);
   // en is only honoured on the final clock of a frame so a frame is never cut short.
   assign stop_s      = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST) && !bus.en;
   assign hs_region_s = (h_cnt_r >= H_SYNC_BEG) && (h_cnt_r < H_SYNC_END);
   assign vs_region_s = (v_cnt_r >= V_SYNC_BEG) && (v_cnt_r < V_SYNC_END);

   // Stream acceptance, next pixel word and state transition for the current position.
   always_comb begin
      state_nxt_s = state_r;
      ready_s     = 1'b0;
      data_nxt_s  = BLANK_W;
      fs_nxt_s    = 1'b0;
      uf_nxt_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.en) begin
               state_nxt_s = ST_SYNC_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SYNC_WAIT: begin
            if (origin_s && bus.s_valid && bus.s_sof) begin
               ready_s     = 1'b1;
               data_nxt_s  = bus.s_data;
               fs_nxt_s    = 1'b1;
               state_nxt_s = ST_STREAM;
            end else begin
               // Stale mid-frame beats are flushed; an SOF beat waits for the frame origin.
               ready_s     = bus.s_valid && !bus.s_sof;
               state_nxt_s = stop_s ? ST_IDLE : ST_SYNC_WAIT;
            end
         end
         ST_STREAM: begin
            if (active_s) begin
               if (!bus.s_valid || (bus.s_sof && !origin_s)) begin
                  uf_nxt_s    = 1'b1;
                  state_nxt_s = ST_SYNC_WAIT;
               end else begin
                  ready_s     = 1'b1;
                  data_nxt_s  = bus.s_data;
                  fs_nxt_s    = origin_s && bus.s_sof;
                  state_nxt_s = ST_STREAM;
               end
            end else begin
               state_nxt_s = stop_s ? ST_IDLE : ST_STREAM;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and raster counters; counters sit at the origin while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         h_cnt_r <= H_ZERO;
         v_cnt_r <= V_ZERO;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_IDLE) begin
            h_cnt_r <= H_ZERO;
            v_cnt_r <= V_ZERO;
         end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= H_ZERO;
            v_cnt_r <= (v_cnt_r == V_LAST) ? V_ZERO : (v_cnt_r + V_ONE);
         end else begin
            h_cnt_r <= h_cnt_r + H_ONE;
         end
      end
   end

   // Encoder-facing outputs, one clock behind the raster position that produced them.
   always_ff @(posedge clk) begin
      if (reset) begin
         ic_hsync_r      <= ~HS_POL;
         ic_vsync_r      <= ~VS_POL;
         ic_data_r       <= BLANK_W;
         frame_start_r   <= 1'b0;
         underflow_r     <= 1'b0;
         underflow_cnt_r <= 16'h0000;
      end else begin
         ic_hsync_r    <= ((state_r != ST_IDLE) && hs_region_s) ? HS_POL : ~HS_POL;
         ic_vsync_r    <= ((state_r != ST_IDLE) && vs_region_s) ? VS_POL : ~VS_POL;
         ic_data_r     <= data_nxt_s;
         frame_start_r <= fs_nxt_s;
         underflow_r   <= uf_nxt_s;
         if (uf_nxt_s && (underflow_cnt_r != 16'hFFFF)) begin
            underflow_cnt_r <= underflow_cnt_r + 16'h0001;
         end
      end
   end

   assign bus.s_ready       = ready_s & ~reset;
   assign bus.ic_hsync      = ic_hsync_r;
   assign bus.ic_vsync      = ic_vsync_r;
   assign bus.ic_data       = ic_data_r;
   assign bus.frame_start   = frame_start_r;
   assign bus.underflow     = underflow_r;
   assign bus.underflow_cnt = underflow_cnt_r;
endmodule

// File: tb/tb_adv7393_timing_gen.sv
// Scoreboard bench for adv7393_timing_gen with a tiny 8x5 raster (H 4/1/2/1, V 2/1/1/1).
// The driver queues the expected encoder outputs for each clock; a monitor pops and compares.
module tb_adv7393_timing_gen;
   localparam logic [15:0] BLANK = 16'h1080;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   adv7393_timing_gen_if #(.DATA_W(16)) bus ();

   adv7393_timing_gen #(
      .DATA_W(16), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .BLANK_VAL(16'h1080)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic [15:0] d;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        uf;
      logic [15:0] cnt;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   int          bh = 0;
   int          bv = 0;
   logic [15:0] ecnt = 16'h0000;

   function automatic logic hs_exp(input int h);
      return !((h == 5) || (h == 6));
   endfunction

   function automatic logic vs_exp(input int v);
      return !(v == 3);
   endfunction

   function automatic logic act(input int h, input int v);
      return (h < 4) && (v < 2);
   endfunction

   // Monitor: compare every registered output against the queued expectation.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         n_vec++;
         if ({bus.ic_data, bus.ic_hsync, bus.ic_vsync, bus.frame_start, bus.underflow, bus.underflow_cnt}
             !== {mon_e.d, mon_e.hs, mon_e.vs, mon_e.fs, mon_e.uf, mon_e.cnt}) begin
            n_err++;
            $display("FAIL %s: got data=%h hs=%b vs=%b fs=%b uf=%b cnt=%h, want data=%h hs=%b vs=%b fs=%b uf=%b cnt=%h",
                     mon_e.tag, bus.ic_data, bus.ic_hsync, bus.ic_vsync, bus.frame_start, bus.underflow,
                     bus.underflow_cnt, mon_e.d, mon_e.hs, mon_e.vs, mon_e.fs, mon_e.uf, mon_e.cnt);
         end
      end
   end

   // One clock of stimulus: drive inputs, queue the output due after the next edge, check s_ready.
   task automatic cyc(input logic rst, input logic e, input logic vld, input logic sof,
                      input logic [15:0] d, input logic run, input logic [15:0] exp_d,
                      input logic exp_fs, input logic exp_uf, input logic exp_rdy, input string tag);
      exp_t x;
      @(negedge clk);
      reset       = rst;
      bus.en      = e;
      bus.s_valid = vld;
      bus.s_sof   = sof;
      bus.s_data  = d;
      if (rst) ecnt = 16'h0000;
      else if (exp_uf && (ecnt != 16'hFFFF)) ecnt = ecnt + 16'h0001;
      x.d   = exp_d;
      x.hs  = run ? hs_exp(bh) : 1'b1;
      x.vs  = run ? vs_exp(bv) : 1'b1;
      x.fs  = exp_fs;
      x.uf  = exp_uf;
      x.cnt = ecnt;
      x.tag = tag;
      sb.push_back(x);
      if (run) begin
         if (bh == 7) begin
            bh = 0;
            bv = (bv == 4) ? 0 : bv + 1;
         end else begin
            bh = bh + 1;
         end
      end else begin
         bh = 0;
         bv = 0;
      end
      #1;
      n_vec++;
      if (bus.s_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL %s s_ready: got %b want %b", tag, bus.s_ready, exp_rdy);
      end
   endtask

   // A well-formed frame (or its first ncyc clocks) starting at the raster origin.
   task automatic stream(input logic [15:0] base, input int ncyc, input int en_off, input string tag);
      int          idx = 0;
      logic        e;
      logic [15:0] d;
      for (int k = 0; k < ncyc; k++) begin
         e = !((k >= en_off) && (k != en_off + 13));
         d = base + 16'(idx);
         if (act(bh, bv)) begin
            cyc(1'b0, e, 1'b1, idx == 0, d, 1'b1, d, idx == 0, 1'b0, 1'b1, tag);
            idx++;
         end else begin
            cyc(1'b0, e, 1'b1, idx == 0, d, 1'b1, BLANK, 1'b0, 1'b0, 1'b0, tag);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, want finish before 200000");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      bus.en      = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      bus.s_data  = 16'h0000;

      // Reset and idle: syncs inactive, blank data, no handshake.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, BLANK, 1'b0, 1'b0, 1'b0, "reset");
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0123, 1'b0, BLANK, 1'b0, 1'b0, 1'b0, "reset_hold");
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0123, 1'b0, BLANK, 1'b0, 1'b0, 1'b0, "idle");
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hA000, 1'b0, BLANK, 1'b0, 1'b0, 1'b0, "idle_en");

      // Continuous, aligned stream over three frames.
      stream(16'hA000, 40, 1000, "frame_a0");
      stream(16'hA100, 40, 1000, "frame_a1");
      stream(16'hA200, 40, 1000, "frame_a2");

      // en dropped (and briefly re-raised) mid-frame: frame completes, then idle.
      stream(16'hB000, 40, 12, "en_drop");
      for (int k = 0; k < 3; k++)
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'hB100, 1'b0, BLANK, 1'b0, 1'b0, 1'b0, "after_en_drop");

      // Three stray non-SOF beats are flushed, then the SOF beat waits for the origin.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'hC0F1, 1'b0, BLANK, 1'b0, 1'b0, 1'b0, "restart_en");
      for (int k = 0; k < 40; k++) begin
         if (k < 3)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'hC0F1 + 16'(k), 1'b1, BLANK, 1'b0, 1'b0, 1'b1, "drop_stray");
         else
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hC000, 1'b1, BLANK, 1'b0, 1'b0, 1'b0, "hold_sof");
      end
      stream(16'hC000, 40, 1000, "frame_c0");
      stream(16'hC100, 40, 1000, "frame_c1");

      // Underflow at line 0 pixel 2: rest of the frame blanked, realign next frame.
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hD000, 1'b1, 16'hD000, 1'b1, 1'b0, 1'b1, "uf_p0");
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'hD001, 1'b1, 16'hD001, 1'b0, 1'b0, 1'b1, "uf_p1");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'hD002, 1'b1, BLANK, 1'b0, 1'b1, 1'b0, "uf_p2");
      for (int k = 3; k < 40; k++)
         cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hE000, 1'b1, BLANK, 1'b0, 1'b0, 1'b0, "uf_blank");
      stream(16'hE000, 40, 1000, "frame_e0");

      // Early SOF at pixel 1: blanked, counted, shown at the next origin.
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hF000, 1'b1, 16'hF000, 1'b1, 1'b0, 1'b1, "mis_p0");
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hF100, 1'b1, BLANK, 1'b0, 1'b1, 1'b0, "mis_p1");
      for (int k = 2; k < 40; k++)
         cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hF100, 1'b1, BLANK, 1'b0, 1'b0, 1'b0, "mis_blank");
      stream(16'hF100, 40, 1000, "frame_f1");

      // Reset at (2,1): immediate reset outputs, the offered beat survives it.
      stream(16'h4000, 10, 1000, "pre_reset");
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h5000, 1'b0, BLANK, 1'b0, 1'b0, 1'b0, "reset_mid");
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h5000, 1'b0, BLANK, 1'b0, 1'b0, 1'b0, "reset_exit");
      stream(16'h5000, 40, 1000, "frame_5");

      // Saturation: preload the counter near its ceiling, then four underflow frames.
      ecnt = 16'hFFFD;
      for (int j = 0; j < 4; j++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h6000 + 16'(j * 256), 1'b1, 16'h6000 + 16'(j * 256),
             1'b1, 1'b0, 1'b1, "sat_p0");
         if (j == 0) begin
            force dut.underflow_cnt_r = 16'hFFFD;
            #1;
            release dut.underflow_cnt_r;
         end
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, BLANK, 1'b0, 1'b1, 1'b0, "sat_uf");
         for (int k = 2; k < 40; k++)
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h6000 + 16'((j + 1) * 256), 1'b1, BLANK,
                1'b0, 1'b0, 1'b0, "sat_blank");
      end

      @(negedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/adv7393_timing_gen.md
ADV7393_TIMING_GEN -- requirements
Module: adv7393_timing_gen

Interface
REQ-001 DATA_W, 16, pixel word width on s_data/ic_data (8 or 16).
REQ-002 H_ACTIVE/H_FP/H_SYNC/H_BP, 720/16/62/60, horizontal timing in clocks; H_TOTAL = sum.
REQ-003 V_ACTIVE/V_FP/V_SYNC/V_BP, 480/9/6/30, vertical timing in lines; V_TOTAL = sum.
REQ-004 HS_POL/VS_POL, 0/0, sync active level (0 = active-low).
REQ-005 BLANK_VAL, 16'h1080, word driven on ic_data outside active video or on underflow; truncated to DATA_W.
REQ-006 clk  in  1  pixel clock; single clock domain; reset is synchronous and active-high.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 en  in  1  enable; sampled at start and at frame boundary.
REQ-009 s_data  in  DATA_W  pixel stream data.
REQ-010 s_valid  in  1  stream beat valid.
REQ-011 s_sof  in  1  beat is first pixel of a frame.
REQ-012 s_ready  out  1  beat accepted when s_valid && s_ready.
REQ-013 ic_hsync  out  1  registered horizontal sync to encoder.
REQ-014 ic_vsync  out  1  registered vertical sync to encoder.
REQ-015 ic_data  out  DATA_W  registered pixel data to encoder.
REQ-016 frame_start  out  1  one-clock pulse aligned with first active pixel on ic_data.
REQ-017 underflow  out  1  one-clock pulse, aligned with blanked active pixel on ic_data.
REQ-018 underflow_cnt  out  16  count of underflow pulses, saturating at 16'hFFFF.

Function
REQ-019 Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1; h wraps to 0 and v increments at h_cnt=H_TOTAL-1; v wraps to 0 at V_TOTAL-1.
REQ-020 Line/frame order: active, front porch, sync, back porch; active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
REQ-021 hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync asserted (whole lines) for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; output levels per HS_POL/VS_POL.
REQ-022 All ic_* outputs, frame_start and underflow are registered: exactly one clock latency from counter position to output.
REQ-023 States: IDLE, SYNC_WAIT, STREAM.
REQ-024 IDLE: counters held at 0, syncs inactive, ic_data=BLANK_VAL, s_ready=0; en=1 -> SYNC_WAIT, counters start next clock from (0,0).
REQ-025 SYNC_WAIT: counters run; ic_data=BLANK_VAL; s_ready = s_valid && !s_sof (non-SOF beats dropped); SOF beat held unconsumed.
REQ-026 SYNC_WAIT -> STREAM when at (h,v)=(0,0) with s_valid && s_sof: that beat is consumed and output as first pixel, frame_start pulses.
REQ-027 STREAM: s_ready=1 exactly during active pixels; accepted s_data appears on ic_data one clock later; outside active, s_ready=0 and ic_data=BLANK_VAL.
REQ-028 STREAM underflow: active pixel with s_valid=0 -> ic_data=BLANK_VAL, underflow pulse, underflow_cnt++, state -> SYNC_WAIT; remainder of frame blanked.
REQ-029 STREAM misalignment: s_valid && s_sof at active pixel other than (0,0) -> beat not consumed, pixel blanked, underflow pulse counted, state -> SYNC_WAIT.
REQ-030 en=0 takes effect only at last clock of frame (H_TOTAL-1,V_TOTAL-1): state -> IDLE; en toggling mid-frame has no effect.
REQ-031 Timing counters never stall for stream state; sync output is continuous in SYNC_WAIT and STREAM.

Reset
REQ-032 reset (synchronous, wins over all) -> IDLE, counters 0, ic_hsync=!HS_POL, ic_vsync=!VS_POL, ic_data=BLANK_VAL, s_ready=0, frame_start=0, underflow=0, underflow_cnt=0 on the next clock edge.
REQ-033 reset mid-frame aborts immediately; no partial-frame completion; stream beats presented during reset are not consumed.

Verification (params H 4/1/2/1, V 2/1/1/1, DATA_W=16)
REQ-034 en=1, continuous stream 8 px/frame, first with s_sof -> ic_data = pixels at h=0..3 on lines 0,1, hsync low at h=5,6 every line, vsync low on line 3, frame_start once per frame, underflow_cnt=0.
REQ-035 Stream 3 non-SOF beats then SOF frame -> 3 beats dropped, output starts at next (0,0) with SOF pixel.
REQ-036 s_valid=0 at line 0 pixel 2 -> ic_data=16'h1080 there and rest of frame, underflow pulse, underflow_cnt=1, realign at next SOF frame.
REQ-037 s_sof at pixel 1 in STREAM -> pixel blanked, underflow_cnt=1, SOF beat displayed at next frame's (0,0).
REQ-038 en dropped at mid-frame -> frame completes with correct syncs, IDLE after (7,4); reset asserted at (2,1) -> outputs at reset values next clock, underflow_cnt=0.
REQ-039 Force 65540 underflows -> underflow_cnt holds 16'hFFFF.
